// File: rtl/cv32e41p_apu_core_pkg.sv
// APU opcode and flag definitions shared by the divide responder and its initiators.
package cv32e41p_apu_core_pkg;

  localparam int unsigned APU_DIVU = 0;
  localparam int unsigned APU_DIV  = 1;
  localparam int unsigned APU_REMU = 2;
  localparam int unsigned APU_REM  = 3;

  localparam int unsigned APU_FLAG_NV = 4;
  localparam int unsigned APU_FLAG_DZ = 3;

endpackage

// File: rtl/cv32e41p_pkg.sv
// Core-wide type definitions used by the divide responder FSM.
package cv32e41p_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

endpackage

// File: rtl/cv32e41p_apu_div_responder_if.sv
// APU request/response bundle between a core (master) and a shared unit (slave).
interface cv32e41p_apu_div_responder_if #(
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NUSFLAGS_CPU = 5
);

  logic                               apu_req;
  logic                               apu_gnt;
  logic [APU_NARGS_CPU-1:0][31:0]     apu_operands;
  logic [APU_WOP_CPU-1:0]             apu_op;
  logic                               apu_rvalid;
  logic [31:0]                        apu_result;
  logic [APU_NUSFLAGS_CPU-1:0]        apu_rflags;

  modport master (
    output apu_req, apu_operands, apu_op,
    input  apu_gnt, apu_rvalid, apu_result, apu_rflags
  );

  modport slave (
    input  apu_req, apu_operands, apu_op,
    output apu_gnt, apu_rvalid, apu_result, apu_rflags
  );

endinterface

// File: rtl/cv32e41p_apu_div_datapath.sv
// Radix-2 restoring divider on operand magnitudes, with sign fix-up of the outputs.
// quotient_o/remainder_o reflect the state after the step taken in the current cycle.
module cv32e41p_apu_div_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        signed_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] rem_q, quot_q, dvsr_q;
  logic        neg_quot_q, neg_rem_q;

  logic [32:0] rem_sh, diff;
  logic        qbit;
  logic [31:0] rem_d, quot_d;
  logic        a_neg, b_neg;

  assign a_neg = signed_i & dividend_i[31];
  assign b_neg = signed_i & divisor_i[31];

  // rem_sh < 2*divisor, so a 33-bit difference keeps its sign in bit 32.
  assign rem_sh = {rem_q, quot_q[31]};
  assign diff   = rem_sh - {1'b0, dvsr_q};
  assign qbit   = ~diff[32];
  assign rem_d  = qbit ? diff[31:0] : rem_sh[31:0];
  assign quot_d = {quot_q[30:0], qbit};

  assign quotient_o  = neg_quot_q ? (32'd0 - quot_d) : quot_d;
  assign remainder_o = neg_rem_q  ? (32'd0 - rem_d)  : rem_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (start_i) begin
      rem_q      <= '0;
      quot_q     <= a_neg ? (32'd0 - dividend_i) : dividend_i;
      dvsr_q     <= b_neg ? (32'd0 - divisor_i) : divisor_i;
      neg_quot_q <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

endmodule

// File: rtl/cv32e41p_apu_div_responder.sv
// APU-side integer divide/remainder responder: handshake, special cases and result registers.
module cv32e41p_apu_div_responder
  import cv32e41p_apu_core_pkg::*;
  import cv32e41p_pkg::*;
#(
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NUSFLAGS_CPU = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cv32e41p_apu_div_responder_if.slave   apu,
  output logic                          busy_o
);

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic        op_rem_q;

  logic [31:0]                 dividend, divisor;
  logic [APU_WOP_CPU-1:0]      op;
  logic                        op_legal, is_signed, is_rem, dz, ovf, special, accept;
  logic [31:0]                 spec_res;
  logic [APU_NUSFLAGS_CPU-1:0] spec_flags;
  logic [31:0]                 quotient, remainder;
  logic                        unused_ops;

  assign dividend   = apu.apu_operands[0];
  assign divisor    = apu.apu_operands[1];
  assign op         = apu.apu_op;
  assign unused_ops = ^apu.apu_operands;

  assign op_legal  = (op == APU_WOP_CPU'(APU_DIVU)) | (op == APU_WOP_CPU'(APU_DIV)) |
                     (op == APU_WOP_CPU'(APU_REMU)) | (op == APU_WOP_CPU'(APU_REM));
  assign is_signed = (op == APU_WOP_CPU'(APU_DIV)) | (op == APU_WOP_CPU'(APU_REM));
  assign is_rem    = (op == APU_WOP_CPU'(APU_REMU)) | (op == APU_WOP_CPU'(APU_REM));
  assign dz        = (divisor == 32'd0);
  assign ovf       = is_signed & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
  assign special   = ~op_legal | dz | ovf;

  assign apu.apu_gnt = apu.apu_req & ((state_q == IDLE) | (state_q == DONE));
  assign accept      = apu.apu_gnt;
  assign busy_o      = (state_q != IDLE);

  // Illegal opcode wins over divide-by-zero.
  always_comb begin
    spec_res   = '0;
    spec_flags = '0;
    if (!op_legal) begin
      spec_flags[APU_FLAG_NV] = 1'b1;
    end else if (dz) begin
      spec_res                = is_rem ? dividend : 32'hFFFF_FFFF;
      spec_flags[APU_FLAG_DZ] = 1'b1;
    end else if (ovf) begin
      spec_res = is_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  cv32e41p_apu_div_datapath u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (accept & ~special),
    .step_i      (state_q == BUSY),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .signed_i    (is_signed),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_rem_q       <= 1'b0;
      apu.apu_rvalid <= 1'b0;
      apu.apu_result <= '0;
      apu.apu_rflags <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          apu.apu_rvalid <= 1'b0;
          state_q        <= IDLE;
          if (accept) begin
            if (special) begin
              state_q        <= DONE;
              apu.apu_rvalid <= 1'b1;
              apu.apu_result <= spec_res;
              apu.apu_rflags <= spec_flags;
            end else begin
              state_q  <= BUSY;
              cnt_q    <= '0;
              op_rem_q <= is_rem;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q        <= DONE;
            apu.apu_rvalid <= 1'b1;
            apu.apu_result <= op_rem_q ? remainder : quotient;
            apu.apu_rflags <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e41p_apu_div_responder.sv
// Directed bench for the APU divide responder: vector table plus handshake/reset sequences.
module tb_cv32e41p_apu_div_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   tot = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cv32e41p_apu_div_responder_if #(
    .APU_NARGS_CPU    (3),
    .APU_WOP_CPU      (6),
    .APU_NUSFLAGS_CPU (5)
  ) apu_bus ();

  cv32e41p_apu_div_responder #(
    .APU_NARGS_CPU    (3),
    .APU_WOP_CPU      (6),
    .APU_NUSFLAGS_CPU (5)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .apu    (apu_bus),
    .busy_o (busy)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flags;
    int          lat;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    apu_bus.apu_op          = op;
    apu_bus.apu_operands[0] = a;
    apu_bus.apu_operands[1] = b;
    apu_bus.apu_operands[2] = 32'hDEAD_BEEF;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    logic [31:0] res_seen;
    @(negedge clk);
    apu_bus.apu_req = 1'b1;
    drive(v.op, v.a, v.b);
    #1;
    chk($sformatf("v%0d gnt", idx), 32'(apu_bus.apu_gnt), 32'd1);
    @(posedge clk);
    #1;
    apu_bus.apu_req = 1'b0;
    drive(6'h2A, 32'h1234_5678, 32'h0000_0003);
    lat = 0;
    while (lat < 40) begin
      lat++;
      @(negedge clk);
      if (apu_bus.apu_rvalid) break;
    end
    chk($sformatf("v%0d lat", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d res", idx), apu_bus.apu_result, v.res);
    chk($sformatf("v%0d flags", idx), 32'(apu_bus.apu_rflags), 32'(v.flags));
    res_seen = apu_bus.apu_result;
    @(negedge clk);
    chk($sformatf("v%0d pulse", idx), 32'(apu_bus.apu_rvalid), 32'd0);
    chk($sformatf("v%0d hold", idx), apu_bus.apu_result, v.res);
    chk($sformatf("v%0d idle", idx), 32'(busy), 32'd0);
    if (res_seen !== v.res) $display("  vector %0d op=%0d a=%h b=%h", idx, v.op, v.a, v.b);
  endtask

  initial begin
    int k, first_k, second_k, gnt_busy, rv_cnt;
    logic gnt_at_rv;

    vecs[0]  = '{6'd0, 32'd100,        32'd7,          32'd14,         5'h00, 33};
    vecs[1]  = '{6'd3, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   5'h00, 33};
    vecs[2]  = '{6'd1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   5'h00, 33};
    vecs[3]  = '{6'd2, 32'd100,        32'd7,          32'd2,          5'h00, 33};
    vecs[4]  = '{6'd0, 32'd5,          32'd0,          32'hFFFFFFFF,   5'h08, 1};
    vecs[5]  = '{6'd2, 32'd5,          32'd0,          32'd5,          5'h08, 1};
    vecs[6]  = '{6'd1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   5'h00, 1};
    vecs[7]  = '{6'd3, 32'h80000000,   32'hFFFFFFFF,   32'd0,          5'h00, 1};
    vecs[8]  = '{6'd9, 32'd100,        32'd7,          32'd0,          5'h10, 1};
    vecs[9]  = '{6'd1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   5'h00, 33};
    vecs[10] = '{6'd3, 32'd7,          32'hFFFFFFFE,   32'd1,          5'h00, 33};
    vecs[11] = '{6'd0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   5'h00, 33};
    vecs[12] = '{6'd0, 32'd3,          32'd5,          32'd0,          5'h00, 33};
    vecs[13] = '{6'd2, 32'hFFFFFFFF,   32'd10,         32'd5,          5'h00, 33};
    vecs[14] = '{6'd1, 32'h80000000,   32'd1,          32'h80000000,   5'h00, 33};
    vecs[15] = '{6'd1, 32'd5,          32'd0,          32'hFFFFFFFF,   5'h08, 1};
    vecs[16] = '{6'd63, 32'd5,         32'd0,          32'd0,          5'h10, 1};

    rst_n           = 1'b0;
    apu_bus.apu_req = 1'b0;
    drive(6'd0, 32'd0, 32'd0);
    #1;
    chk("rst gnt", 32'(apu_bus.apu_gnt), 32'd0);
    chk("rst rvalid", 32'(apu_bus.apu_rvalid), 32'd0);
    chk("rst result", apu_bus.apu_result, 32'd0);
    chk("rst flags", 32'(apu_bus.apu_rflags), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Back-to-back: request held high across the first completion.
    @(negedge clk);
    apu_bus.apu_req = 1'b1;
    drive(6'd0, 32'd100, 32'd7);
    #1;
    chk("b2b gnt0", 32'(apu_bus.apu_gnt), 32'd1);
    @(posedge clk);
    #1;
    drive(6'd0, 32'd200, 32'd7);
    first_k   = 0;
    gnt_busy  = 0;
    gnt_at_rv = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (apu_bus.apu_rvalid) begin
        first_k   = k;
        gnt_at_rv = apu_bus.apu_gnt;
        break;
      end
      if (apu_bus.apu_gnt) gnt_busy++;
    end
    chk("b2b first lat", 32'(first_k), 32'd33);
    chk("b2b gnt at rvalid", 32'(gnt_at_rv), 32'd1);
    chk("b2b gnt in busy", 32'(gnt_busy), 32'd0);
    chk("b2b first res", apu_bus.apu_result, 32'd14);
    @(posedge clk);
    #1;
    apu_bus.apu_req = 1'b0;
    drive(6'd1, 32'd0, 32'd0);
    second_k = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (apu_bus.apu_rvalid) begin
        second_k = k;
        break;
      end
    end
    chk("b2b gap", 32'(second_k), 32'd33);
    chk("b2b second res", apu_bus.apu_result, 32'd28);

    // Reset mid-operation drops the request and clears outputs at once.
    @(negedge clk);
    apu_bus.apu_req = 1'b1;
    drive(6'd0, 32'd1000, 32'd10);
    @(posedge clk);
    #1;
    apu_bus.apu_req = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("pre-rst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst rvalid", 32'(apu_bus.apu_rvalid), 32'd0);
    chk("mid rst result", apu_bus.apu_result, 32'd0);
    chk("mid rst flags", 32'(apu_bus.apu_rflags), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    rv_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (apu_bus.apu_rvalid) rv_cnt++;
    end
    chk("dropped rvalid", 32'(rv_cnt), 32'd0);
    run_vec(100, '{6'd0, 32'd77, 32'd7, 32'd11, 5'h00, 33});

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
